// File: rtl/seq_mult32.sv
// Multi-cycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier.
// One partial-product row per clock; start/done handshake, fixed latency of WIDTH cycles.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one shift-and-add iteration per cycle, busy=1
// DONE   | product just updated, done=1; start here begins a new run
module seq_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplr;
  logic [WIDTH-1:0]     acc_hi;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     pp;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic                 accept;
  logic                 last;

  // {sum, mplr} >> 1 always has a zero MSB, so only the low 2*WIDTH bits are kept
  always_comb begin
    pp      = mcand & {WIDTH{mplr[0]}};
    sum     = {1'b0, acc_hi} + {1'b0, pp};
    acc_nxt = {sum, mplr[WIDTH-1:1]};
    last    = (cnt == CNT_LAST);
    accept  = start && (state != S_RUN);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplr    <= '0;
      acc_hi  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= a;
        mplr   <= b;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (state == S_RUN) begin
        acc_hi <= acc_nxt[2*WIDTH-1:WIDTH];
        mplr   <= acc_nxt[WIDTH-1:0];
        cnt    <= cnt + CNT_W'(1);
        if (last) product <= acc_nxt;
      end
    end
  end

endmodule
